// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP weight loader.
// Holds the loader state encoding and the helpers that size the weight
// memory. Each layer stores (N+1)*N words: N inputs plus one bias for each
// of the N neurons.
package mlp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2,
    StErr  = 2'd3
  } load_state_e;

  // Sizes for the default N=2, M=2 build.
  localparam int unsigned DEF_N           = 2;
  localparam int unsigned DEF_M           = 2;
  localparam int unsigned WORDS_PER_LAYER = (DEF_N + 1) * DEF_N;
  localparam int unsigned TOTAL_WORDS     = DEF_M * WORDS_PER_LAYER;

  // The same sizes for any other N and M.
  function automatic int unsigned words_per_layer(input int unsigned n);
    return (n + 1) * n;
  endfunction

  function automatic int unsigned total_words(input int unsigned n, input int unsigned m);
    return m * words_per_layer(n);
  endfunction

  // Index width that never drops to zero when there is only one entry.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mlp_weight_ram.sv
// Weight storage for the MLP: M layers of (N+1)*N words each.
// Ports:
//   clk, n_rst   - clock, asynchronous active-low clear of every word
//   we_i         - write enable
//   wr_layer_i   - layer being written
//   wr_word_i    - word within the layer being written
//   wr_data_i    - write data
//   rd_addr_i    - layer to read; values >= M read as all zeros
//   rd_data_o    - registered read data, one cycle after rd_addr_i
// A read and a write to the same layer in one cycle return the old contents.
module mlp_weight_ram
  import mlp_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned N         = 2,
  parameter int unsigned M         = 2
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic                                   we_i,
  input  logic [idx_width(M)-1:0]                wr_layer_i,
  input  logic [idx_width(words_per_layer(N))-1:0] wr_word_i,
  input  logic [WORD_SIZE-1:0]                   wr_data_i,
  input  logic [$clog2(M):0]                     rd_addr_i,
  output logic [WORD_SIZE-1:0]                   rd_data_o [(N+1)*N-1:0]
);

  localparam int unsigned Wpl    = words_per_layer(N);
  localparam int unsigned LayerW = idx_width(M);
  localparam int unsigned WordW  = idx_width(Wpl);
  localparam int unsigned AddrW  = $clog2(M) + 1;

  logic [WORD_SIZE-1:0] mem_q [M-1:0][Wpl-1:0];
  logic [WORD_SIZE-1:0] rd_d  [Wpl-1:0];
  logic [WORD_SIZE-1:0] rd_q  [Wpl-1:0];

  // Decoded write so that no out-of-range index is ever formed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int l = 0; l < int'(M); l++) begin
        for (int w = 0; w < int'(Wpl); w++) begin
          mem_q[l][w] <= '0;
        end
      end
    end else if (we_i) begin
      for (int l = 0; l < int'(M); l++) begin
        for (int w = 0; w < int'(Wpl); w++) begin
          if (wr_layer_i == LayerW'(l) && wr_word_i == WordW'(w)) begin
            mem_q[l][w] <= wr_data_i;
          end
        end
      end
    end
  end

  // Unmatched addresses (>= M) fall through to the zero default.
  always_comb begin
    for (int w = 0; w < int'(Wpl); w++) begin
      rd_d[w] = '0;
    end
    for (int l = 0; l < int'(M); l++) begin
      if (rd_addr_i == AddrW'(l)) begin
        for (int w = 0; w < int'(Wpl); w++) begin
          rd_d[w] = mem_q[l][w];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int w = 0; w < int'(Wpl); w++) begin
        rd_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < int'(Wpl); w++) begin
        rd_q[w] <= rd_d[w];
      end
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/mlp_weight_loader.sv
// Streams a full set of MLP weights into on-chip storage and serves one
// layer at a time to the datapath. Replaces the file-initialised weight
// memory; rd_addr comes from the MLP FSM layer counter.
// Ports:
//   clk, n_rst        - clock, asynchronous active-low reset
//   load_start        - begin a full load (honoured when idle or in error)
//   s_valid, s_data,
//   s_last, s_ready   - weight stream, layer 0 word 0 first
//   busy              - a load is in progress
//   load_done         - one-cycle pulse after a correctly framed load
//   load_err          - sticky framing error, cleared by load_start
//   weights_ok        - memory holds a complete, error-free load
//   rd_addr           - layer to read
//   rd_weights        - weights of that layer, one cycle later
module mlp_weight_loader
  import mlp_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned N         = 2,
  parameter int unsigned M         = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load_start,
  input  logic                 s_valid,
  input  logic [WORD_SIZE-1:0] s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_err,
  output logic                 weights_ok,
  input  logic [$clog2(M):0]   rd_addr,
  output logic [WORD_SIZE-1:0] rd_weights [(N+1)*N-1:0]
);

  localparam int unsigned Wpl    = words_per_layer(N);
  localparam int unsigned LayerW = idx_width(M);
  localparam int unsigned WordW  = idx_width(Wpl);

  load_state_e       state_q;
  logic [LayerW-1:0] layer_q;
  logic [WordW-1:0]  word_q;
  logic              s_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              ok_q;

  logic xfer;
  logic last_word_of_layer;
  logic final_word;

  assign xfer               = s_valid & s_ready_q;
  assign last_word_of_layer = (word_q == WordW'(Wpl - 1));
  assign final_word         = last_word_of_layer && (layer_q == LayerW'(M - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      layer_q   <= '0;
      word_q    <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StErr: begin
          if (load_start) begin
            state_q   <= StLoad;
            layer_q   <= '0;
            word_q    <= '0;
            err_q     <= 1'b0;
            ok_q      <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StLoad: begin
          // The word is written on every transfer, including a misframed one.
          if (xfer) begin
            if (s_last && final_word) begin
              state_q   <= StDone;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              ok_q      <= 1'b1;
            end else if (s_last || final_word) begin
              state_q   <= StErr;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
              err_q     <= 1'b1;
            end else if (last_word_of_layer) begin
              word_q  <= '0;
              layer_q <= layer_q + LayerW'(1);
            end else begin
              word_q <= word_q + WordW'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign weights_ok = ok_q;

  mlp_weight_ram #(
    .WORD_SIZE(WORD_SIZE),
    .N        (N),
    .M        (M)
  ) u_ram (
    .clk       (clk),
    .n_rst     (n_rst),
    .we_i      (xfer),
    .wr_layer_i(layer_q),
    .wr_word_i (word_q),
    .wr_data_i (s_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_weights)
  );

endmodule

// File: tb/tb_mlp_weight_loader.sv
// Bench for mlp_weight_loader with N=2, M=2 (6 words per layer, 12 total).
// The reference model tracks the load as a count of accepted words and a
// flat copy of the memory; every cycle it predicts the status outputs and
// the registered read data.
module tb_mlp_weight_loader;

  localparam int unsigned WS  = 8;
  localparam int unsigned N   = 2;
  localparam int unsigned M   = 2;
  localparam int unsigned WPL = (N + 1) * N;
  localparam int unsigned TOT = M * WPL;
  localparam int unsigned PW  = WS * WPL;

  localparam int MIdle = 0;
  localparam int MLoad = 1;
  localparam int MDone = 2;
  localparam int MErr  = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          load_start;
  logic          s_valid;
  logic [WS-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          busy;
  logic          load_done;
  logic          load_err;
  logic          weights_ok;
  logic [1:0]    rd_addr;
  logic [WS-1:0] rd_weights [WPL-1:0];

  mlp_weight_loader #(
    .WORD_SIZE(WS),
    .N        (N),
    .M        (M)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .load_start(load_start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err),
    .weights_ok(weights_ok),
    .rd_addr   (rd_addr),
    .rd_weights(rd_weights)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model.
  logic [WS-1:0] ref_mem [M][WPL];
  int            mode;
  int            k;
  bit            m_err;
  bit            m_ok;
  int            done_seen;

  typedef struct {
    bit            toggle;
    int            n_words;
    int            last_at;
    int            exp_done;
    bit            exp_err;
    bit            exp_ok;
    logic [PW-1:0] exp_l0;
    logic [PW-1:0] exp_l1;
  } scen_t;

  scen_t tbl [4];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] pack_dut();
    logic [PW-1:0] p;
    for (int i = 0; i < int'(WPL); i++) p[i*WS +: WS] = rd_weights[i];
    return p;
  endfunction

  function automatic logic [PW-1:0] pack_ref(input int layer);
    logic [PW-1:0] p;
    p = '0;
    if (layer < int'(M)) begin
      for (int i = 0; i < int'(WPL); i++) p[i*WS +: WS] = ref_mem[layer][i];
    end
    return p;
  endfunction

  task automatic model_reset();
    mode  = MIdle;
    k     = 0;
    m_err = 1'b0;
    m_ok  = 1'b0;
    for (int l = 0; l < int'(M); l++)
      for (int w = 0; w < int'(WPL); w++) ref_mem[l][w] = '0;
  endtask

  // One clock: predict from the current inputs, advance, compare.
  task automatic cycle();
    logic [PW-1:0] exp_rd;
    logic [4:0]    exp_st;
    logic [4:0]    act_st;
    exp_rd = pack_ref(int'(rd_addr));
    case (mode)
      MIdle, MErr: begin
        if (load_start) begin
          mode  = MLoad;
          k     = 0;
          m_err = 1'b0;
          m_ok  = 1'b0;
        end
      end
      MLoad: begin
        if (s_valid) begin
          ref_mem[k / int'(WPL)][k % int'(WPL)] = s_data;
          if (s_last && k == int'(TOT) - 1) begin
            mode = MDone;
            m_ok = 1'b1;
          end else if (s_last || k == int'(TOT) - 1) begin
            mode  = MErr;
            m_err = 1'b1;
          end
          k++;
        end
      end
      default: mode = MIdle;
    endcase
    @(posedge clk);
    #1;
    if (load_done) done_seen++;
    exp_st = {mode == MLoad, mode == MLoad, mode == MDone, m_err, m_ok};
    act_st = {s_ready, busy, load_done, load_err, weights_ok};
    check("status{ready,busy,done,err,ok}", PW'(act_st), PW'(exp_st));
    check("rd_weights", pack_dut(), exp_rd);
  endtask

  // Reset is asserted between clock edges and checked before the next edge.
  task automatic do_reset();
    load_start = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("reset_outputs", PW'({s_ready, busy, load_done, load_err, weights_ok}), '0);
    check("reset_rd_weights", pack_dut(), '0);
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic send(input logic [WS-1:0] data, input bit last);
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    cycle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
  endtask

  initial begin
    int idx;
    int cyc;

    n_rst      = 1'b1;
    load_start = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    rd_addr    = '0;
    done_seen  = 0;
    model_reset();

    tbl[0] = '{0, 12, 12, 1, 1'b0, 1'b1, 48'h060504030201, 48'h0C0B0A090807};
    tbl[1] = '{1, 12, 12, 1, 1'b0, 1'b1, 48'h060504030201, 48'h0C0B0A090807};
    tbl[2] = '{0, 5,  5,  0, 1'b1, 1'b0, 48'h000504030201, 48'h000000000000};
    tbl[3] = '{0, 12, 0,  0, 1'b1, 1'b0, 48'h060504030201, 48'h0C0B0A090807};

    // Framing scenarios, each from a fresh reset.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      done_seen = 0;
      rd_addr   = 2'd0;
      start_load();
      idx = 0;
      cyc = 0;
      while (idx < tbl[r].n_words && cyc < 64) begin
        s_valid = tbl[r].toggle ? (cyc % 2 == 0) : 1'b1;
        s_data  = WS'(idx + 1);
        s_last  = (idx + 1 == tbl[r].last_at);
        cycle();
        if (s_valid) idx++;
        cyc++;
      end
      check("words_sent", PW'(idx), PW'(tbl[r].n_words));
      s_valid = 1'b0;
      s_last  = 1'b0;
      cycle();
      cycle();
      check("done_pulses", PW'(done_seen), PW'(tbl[r].exp_done));
      check("load_err", PW'(load_err), PW'(tbl[r].exp_err));
      check("weights_ok", PW'(weights_ok), PW'(tbl[r].exp_ok));
      rd_addr = 2'd0;
      cycle();
      check("layer0", pack_dut(), tbl[r].exp_l0);
      rd_addr = 2'd1;
      cycle();
      check("layer1", pack_dut(), tbl[r].exp_l1);
      rd_addr = 2'd2;
      cycle();
      check("rd_addr_out_of_range", pack_dut(), '0);
      // A new request clears the error and starts loading again.
      start_load();
      check("err_cleared", PW'(load_err), '0);
      check("busy_after_start", PW'(busy), PW'(1));
    end

    // Read-before-write on layer 0 while reloading it.
    do_reset();
    start_load();
    for (int i = 0; i < int'(TOT); i++) send(WS'(i + 1), i == int'(TOT) - 1);
    cycle();
    start_load();
    rd_addr = 2'd1;
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    rd_addr = 2'd0;
    send(8'hA3, 1'b0);
    check("read_before_write_old", pack_dut(), 48'h060504A2A1A0);
    cycle();
    check("read_after_write_new", pack_dut(), 48'h0605A3A2A1A0);
    rd_addr = 2'd3;
    cycle();
    check("rd_addr3_zero", pack_dut(), '0);

    // Reset in the middle of a load abandons it.
    do_reset();
    start_load();
    for (int i = 0; i < 7; i++) send(WS'(8'h40 + i), 1'b0);
    do_reset();
    s_valid = 1'b1;
    s_data  = 8'h55;
    rd_addr = 2'd0;
    cycle();
    rd_addr = 2'd1;
    cycle();
    check("ready_low_after_reset", PW'(s_ready), '0);
    s_valid = 1'b0;
    start_load();
    check("ready_after_new_start", PW'(s_ready), PW'(1));

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      load_start = ($urandom % 10 == 0);
      s_valid    = $urandom % 2;
      s_data     = WS'($urandom);
      if (mode == MLoad && k == int'(TOT) - 1) s_last = ($urandom % 4 != 0);
      else s_last = ($urandom % 20 == 0);
      rd_addr = 2'($urandom % 4);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
